// File: rtl/checkbits_mon_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// checkbits_mon_pkg: shared state encoding and default sizing for the monitor
// Rev 1.0
// ----------------------------------------------------------------------------
package checkbits_mon_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } mon_state_e;

endpackage : checkbits_mon_pkg
`default_nettype wire

// File: rtl/checkbits_seq_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// checkbits_seq_mem: DEPTH x 2*WIDTH register file, one write / one async read
// Rev 1.0
// ----------------------------------------------------------------------------
module checkbits_seq_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64
) (
  input  logic                       axis_clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [2*WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [2*WIDTH-1:0]         rdata
);

  // Contents are intentionally left unreset; entries are defined once written.
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge axis_clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : checkbits_seq_mem
`default_nettype wire

// File: rtl/checkbits_seq_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// checkbits_seq_monitor: waits for an ordered list of masked values on a bus
// Rev 1.0
// ----------------------------------------------------------------------------
module checkbits_seq_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                         axis_clk,
  input  logic                         axis_rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(DEPTH)-1:0]     cfg_addr,
  input  logic [WIDTH-1:0]             cfg_data,
  input  logic [WIDTH-1:0]             cfg_mask,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             checkbits,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic                         match_valid,
  output logic [$clog2(DEPTH)-1:0]     match_idx,
  output logic [CNT_W-1:0]             match_cycle,
  output logic [CNT_W-1:0]             latency,
  output logic                         latency_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  mon_state_e         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               mv_q, mv_d;
  logic [IDX_W-1:0]   midx_q, midx_d;
  logic [CNT_W-1:0]   mcyc_q, mcyc_d;
  logic [CNT_W-1:0]   lat_q, lat_d;
  logic               lv_q, lv_d;

  logic               mem_we;
  logic [2*WIDTH-1:0] entry;
  logic [WIDTH-1:0]   exp_val;
  logic [WIDTH-1:0]   exp_mask;
  logic               hit;
  logic               last;

  assign mem_we = cfg_we && (state_q != ST_RUN);

  checkbits_seq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .axis_clk (axis_clk),
    .we       (mem_we),
    .waddr    (cfg_addr),
    .wdata    ({cfg_data, cfg_mask}),
    .raddr    (idx_q),
    .rdata    (entry)
  );

  assign exp_val  = entry[2*WIDTH-1:WIDTH];
  assign exp_mask = entry[WIDTH-1:0];
  assign hit      = ((checkbits ^ exp_val) & exp_mask) == '0;
  assign last     = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    mv_d    = 1'b0;
    midx_d  = midx_q;
    mcyc_d  = mcyc_q;
    lat_d   = lat_q;
    lv_d    = lv_q;

    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      lat_d   = '0;
      lv_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start && (cfg_len != '0)) begin
            state_d = ST_RUN;
            len_d   = cfg_len;
            idx_d   = '0;
            cnt_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            lat_d   = '0;
            lv_d    = 1'b0;
          end
        end
        ST_RUN: begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
          if (hit) begin
            mv_d   = 1'b1;
            midx_d = idx_q;
            mcyc_d = cnt_q;
          end
          // The final match wins over a timeout landing in the same cycle.
          if (hit && last) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
            lat_d   = cnt_q;
            lv_d    = 1'b1;
          end else begin
            if (hit) begin
              idx_d = idx_q + IDX_W'(1);
            end
            if (cnt_q == TO_LAST) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      mv_q    <= 1'b0;
      midx_q  <= '0;
      mcyc_q  <= '0;
      lat_q   <= '0;
      lv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      mv_q    <= mv_d;
      midx_q  <= midx_d;
      mcyc_q  <= mcyc_d;
      lat_q   <= lat_d;
      lv_q    <= lv_d;
    end
  end

  assign busy          = (state_q == ST_RUN);
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign match_valid   = mv_q;
  assign match_idx     = midx_q;
  assign match_cycle   = mcyc_q;
  assign latency       = lat_q;
  assign latency_valid = lv_q;

endmodule : checkbits_seq_monitor
`default_nettype wire

// File: tb/tb_checkbits_seq_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_checkbits_seq_monitor: directed scenarios with hand-computed expectations
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_checkbits_seq_monitor;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 16;
  localparam int TO = 100;
  localparam int IW = $clog2(D);
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [W-1:0]  cfg_mask;
  logic [LW-1:0] cfg_len;
  logic          start;
  logic          abort;
  logic [W-1:0]  checkbits;
  logic          busy, pass, fail, match_valid, latency_valid;
  logic [IW-1:0] match_idx;
  logic [CW-1:0] match_cycle, latency;

  int total = 0;
  int bad   = 0;

  checkbits_seq_monitor #(
    .WIDTH (W), .DEPTH (D), .CNT_W (CW), .TIMEOUT (TO)
  ) dut (
    .axis_clk      (clk),
    .axis_rst_n    (rst_n),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .cfg_mask      (cfg_mask),
    .cfg_len       (cfg_len),
    .start         (start),
    .abort         (abort),
    .checkbits     (checkbits),
    .busy          (busy),
    .pass          (pass),
    .fail          (fail),
    .match_valid   (match_valid),
    .match_idx     (match_idx),
    .match_cycle   (match_cycle),
    .latency       (latency),
    .latency_valid (latency_valid)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_mask = m;
    cyc();
    cfg_we = 1'b0;
  endtask

  // After return the first RUN cycle (counter 0) is current.
  task automatic go(input logic [LW-1:0] n);
    start = 1'b1; cfg_len = n;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    total++;
    if ({busy, pass, fail, match_valid, latency_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000", {busy, pass, fail, match_valid, latency_valid});
    end
    total++;
    if (match_idx !== '0 || match_cycle !== '0 || latency !== '0) begin
      bad++; $display("FAIL reset_values got idx=%0d cyc=%0d lat=%0d want 0/0/0", match_idx, match_cycle, latency);
    end
    rst_n = 1'b1;
    cyc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_masked();
    wr(0, 16'h00A5, 16'h00FF);
    wr(1, 16'hFF5A, 16'hFFFF);
    checkbits = 16'h0000;
    go(2);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL masked_busy got=%b want=1", busy); end
    for (int k = 0; k < 12; k++) begin
      checkbits = (k == 3) ? 16'h12A5 : (k == 10) ? 16'hFF5A : 16'h0000;
      cyc();
      total++;
      if (match_valid !== ((k == 3) || (k == 10))) begin
        bad++; $display("FAIL masked_mv cycle %0d got=%b want=%b", k, match_valid, (k == 3) || (k == 10));
      end
      if (k == 3) begin
        total++;
        if (match_idx !== 3'd0 || match_cycle !== 16'd3) begin
          bad++; $display("FAIL masked_m0 got idx=%0d cyc=%0d want 0/3", match_idx, match_cycle);
        end
      end
      if (k == 10) begin
        total++;
        if (match_idx !== 3'd1 || match_cycle !== 16'd10 || {pass, latency_valid, busy} !== 3'b110 || latency !== 16'd10) begin
          bad++; $display("FAIL masked_final got idx=%0d cyc=%0d p/lv/b=%b lat=%0d want 1/10/110/10",
                          match_idx, match_cycle, {pass, latency_valid, busy}, latency);
        end
      end
    end
    checkbits = 16'h0000;
  endtask

  task automatic test_order();
    logic [W-1:0] vals [11];
    int           eidx [11];
    vals = '{16'h0007, 16'd893, 16'h1111, 16'd40, 16'd893, 16'h2222, 16'd2669,
             16'd2541, 16'd2669, 16'h3333, 16'hAB71};
    eidx = '{-1, -1, -1, 0, 1, -1, -1, 2, 3, -1, 4};
    wr(0, 16'd40,   16'hFFFF);
    wr(1, 16'd893,  16'hFFFF);
    wr(2, 16'd2541, 16'hFFFF);
    wr(3, 16'd2669, 16'hFFFF);
    wr(4, 16'hAB71, 16'hFFFF);
    go(5);
    total++;
    if (pass !== 1'b0 || latency_valid !== 1'b0) begin
      bad++; $display("FAIL order_clear got pass=%b lv=%b want 0/0", pass, latency_valid);
    end
    for (int k = 0; k < 11; k++) begin
      checkbits = vals[k];
      cyc();
      total++;
      if (match_valid !== (eidx[k] >= 0)) begin
        bad++; $display("FAIL order_mv cycle %0d got=%b want=%b", k, match_valid, eidx[k] >= 0);
      end
      if (eidx[k] >= 0) begin
        total++;
        if (match_idx !== IW'(eidx[k]) || match_cycle !== CW'(k)) begin
          bad++; $display("FAIL order_match cycle %0d got idx=%0d cyc=%0d want %0d/%0d", k, match_idx, match_cycle, eidx[k], k);
        end
      end
    end
    total++;
    if (pass !== 1'b1 || latency !== 16'd10 || busy !== 1'b0) begin
      bad++; $display("FAIL order_pass got pass=%b lat=%0d busy=%b want 1/10/0", pass, latency, busy);
    end
    checkbits = 16'h0000;
  endtask

  task automatic test_double();
    wr(0, 16'h0001, 16'hFFFF);
    wr(1, 16'h0001, 16'hFFFF);
    go(2);
    for (int k = 0; k < 6; k++) begin
      checkbits = (k == 2) ? 16'h0001 : 16'h0000;
      cyc();
      total++;
      if (match_valid !== (k == 2)) begin
        bad++; $display("FAIL double1_mv cycle %0d got=%b want=%b", k, match_valid, k == 2);
      end
    end
    total++;
    if (match_idx !== 3'd0 || busy !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL double1_state got idx=%0d busy=%b pass=%b want 0/1/0", match_idx, busy, pass);
    end
    abort = 1'b1; cyc(); abort = 1'b0;
    go(2);
    checkbits = 16'h0001;
    cyc();
    total++;
    if (match_valid !== 1'b1 || match_idx !== 3'd0 || pass !== 1'b0) begin
      bad++; $display("FAIL double2_first got mv=%b idx=%0d pass=%b want 1/0/0", match_valid, match_idx, pass);
    end
    cyc();
    total++;
    if (match_valid !== 1'b1 || match_idx !== 3'd1 || pass !== 1'b1 || latency !== 16'd1) begin
      bad++; $display("FAIL double2_final got mv=%b idx=%0d pass=%b lat=%0d want 1/1/1/1", match_valid, match_idx, pass, latency);
    end
    checkbits = 16'h0000;
  endtask

  task automatic test_timeout();
    wr(0, 16'h5555, 16'hFFFF);
    checkbits = 16'h0000;
    go(1);
    for (int k = 0; k < TO - 1; k++) cyc();
    total++;
    if (busy !== 1'b1 || fail !== 1'b0) begin
      bad++; $display("FAIL timeout_early got busy=%b fail=%b want 1/0", busy, fail);
    end
    cyc();
    total++;
    if (fail !== 1'b1 || busy !== 1'b0 || pass !== 1'b0) begin
      bad++; $display("FAIL timeout_fail got fail=%b busy=%b pass=%b want 1/0/0", fail, busy, pass);
    end
    go(1);
    total++;
    if (fail !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_restart got fail=%b busy=%b want 0/1", fail, busy);
    end
    for (int k = 0; k < TO - 1; k++) cyc();
    checkbits = 16'h5555;
    cyc();
    total++;
    if (pass !== 1'b1 || fail !== 1'b0 || latency !== 16'd99 || latency_valid !== 1'b1) begin
      bad++; $display("FAIL timeout_edge got pass=%b fail=%b lat=%0d lv=%b want 1/0/99/1", pass, fail, latency, latency_valid);
    end
    checkbits = 16'h0000;
  endtask

  task automatic test_abort();
    abort = 1'b1; cyc(); abort = 1'b0;
    total++;
    if (pass !== 1'b0 || latency_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_pass got pass=%b lv=%b busy=%b want 0/0/0", pass, latency_valid, busy);
    end
    wr(0, 16'h00F0, 16'hFFFF);
    wr(1, 16'h00F1, 16'hFFFF);
    wr(2, 16'h00F2, 16'hFFFF);
    go(3);
    for (int k = 0; k < 5; k++) cyc();
    checkbits = 16'h00F0; abort = 1'b1;
    cyc();
    abort = 1'b0; checkbits = 16'h0000;
    total++;
    if ({busy, pass, fail, match_valid} !== 4'b0000) begin
      bad++; $display("FAIL abort_run got b/p/f/mv=%b want 0000", {busy, pass, fail, match_valid});
    end
    start = 1'b1; abort = 1'b1; cfg_len = 3;
    cyc();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_over_start got busy=%b want 0", busy); end
    wr(0, 16'h0042, 16'hFFFF);
    go(1);
    cfg_we = 1'b1; cfg_addr = 0; cfg_data = 16'h0099; cfg_mask = 16'hFFFF;
    cyc();
    cfg_we = 1'b0;
    checkbits = 16'h0099;
    cyc();
    total++;
    if (match_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL run_write got mv=%b busy=%b want 0/1", match_valid, busy);
    end
    checkbits = 16'h0042;
    cyc();
    total++;
    if (pass !== 1'b1 || match_cycle !== 16'd2) begin
      bad++; $display("FAIL run_write_pass got pass=%b cyc=%0d want 1/2", pass, match_cycle);
    end
    checkbits = 16'h0000;
    go(1);
    cyc();
    checkbits = 16'h0042; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; checkbits = 16'h0000;
    total++;
    if ({busy, pass, fail, match_valid, latency_valid} !== 5'b0 || match_idx !== '0 || match_cycle !== '0 || latency !== '0) begin
      bad++; $display("FAIL midrun_reset got flags=%b idx=%0d cyc=%0d lat=%0d want all 0",
                      {busy, pass, fail, match_valid, latency_valid}, match_idx, match_cycle, latency);
    end
  endtask

  task automatic test_restart();
    wr(0, 16'h0010, 16'hFFFF);
    wr(1, 16'h0020, 16'hFFFF);
    wr(2, 16'h0030, 16'hFFFF);
    go(1);
    for (int k = 0; k < 5; k++) begin
      checkbits = (k == 4) ? 16'h0010 : 16'h0000;
      cyc();
    end
    checkbits = 16'h0000;
    go(0);
    total++;
    if (busy !== 1'b0 || pass !== 1'b1 || latency_valid !== 1'b1 || latency !== 16'd4) begin
      bad++; $display("FAIL restart_len0 got busy=%b pass=%b lv=%b lat=%0d want 0/1/1/4", busy, pass, latency_valid, latency);
    end
    go(3);
    total++;
    if (busy !== 1'b1 || pass !== 1'b0 || latency_valid !== 1'b0) begin
      bad++; $display("FAIL restart_clear got busy=%b pass=%b lv=%b want 1/0/0", busy, pass, latency_valid);
    end
    checkbits = 16'h0010;
    cyc();
    checkbits = 16'h0020; start = 1'b1; cfg_len = 1;
    cyc();
    start = 1'b0;
    checkbits = 16'h0030;
    cyc();
    checkbits = 16'h0000;
    total++;
    if (pass !== 1'b1 || match_idx !== 3'd2 || latency !== 16'd2 || match_valid !== 1'b1) begin
      bad++; $display("FAIL restart_run got pass=%b idx=%0d lat=%0d mv=%b want 1/2/2/1", pass, match_idx, latency, match_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0;
    cfg_len = '0; start = 1'b0; abort = 1'b0; checkbits = '0;
    test_reset();
    test_masked();
    test_order();
    test_double();
    test_timeout();
    test_abort();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_checkbits_seq_monitor
`default_nettype wire

// File: doc/checkbits_seq_monitor.md
CHECKBITS_SEQ_MONITOR -- requirements
Module: checkbits_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: checkbits bus width.
REQ-002 SHALL have parameter DEPTH, default 64: maximum expected-sequence length.
REQ-003 SHALL have parameter CNT_W, default 32: cycle counter and latency width.
REQ-004 SHALL have parameter TIMEOUT, default 1000000: cycles allowed per run before failure.
REQ-005 SHALL have ports, in order:
- axis_clk  in  1  sole clock.
- axis_rst_n  in  1  synchronous active-low reset.
- cfg_we  in  1  write sequence entry.
- cfg_addr  in  clog2(DEPTH)  entry index.
- cfg_data  in  WIDTH  expected value.
- cfg_mask  in  WIDTH  compare mask; 1 = bit compared.
- cfg_len  in  clog2(DEPTH+1)  number of entries in the run.
- start  in  1  begin run (pulse).
- abort  in  1  cancel run.
- checkbits  in  WIDTH  observed status bus.
- busy  out  1  run in progress.
- pass  out  1  sequence completed.
- fail  out  1  timeout occurred.
- match_valid  out  1  one-cycle pulse per matched entry.
- match_idx  out  clog2(DEPTH)  index of the matched entry.
- match_cycle  out  CNT_W  run cycle of the match.
- latency  out  CNT_W  run cycle of the final match.
- latency_valid  out  1  latency holds a valid result.

Function
REQ-006 SHALL implement states IDLE, RUN, PASS, FAIL.
REQ-007 SHALL write {cfg_data, cfg_mask} to entry cfg_addr on cfg_we only when not in RUN; cfg_we in RUN SHALL be ignored.
REQ-008 SHALL go from IDLE, PASS or FAIL to RUN on start when cfg_len is nonzero; start with cfg_len of 0 SHALL be ignored.
REQ-009 SHALL, on entering RUN, latch cfg_len, clear the entry index and cycle counter, and clear pass, fail and latency_valid.
REQ-010 SHALL hold the cycle counter at 0 in the first RUN cycle and increment it by 1 each later RUN cycle, saturating at all-ones.
REQ-011 SHALL match the current entry in a RUN cycle when (checkbits AND mask) equals (expected AND mask).
REQ-012 SHALL match at most one entry per cycle and advance the index by 1, even if checkbits also matches the next entry.
REQ-013 SHALL treat non-matching checkbits values as don't-care: no failure and no index change.
REQ-014 SHALL assert match_valid for one cycle, registered one cycle after the matching sample, with match_idx and match_cycle equal to the index and counter at the match.
REQ-015 SHALL go to PASS when entry len-1 matches, set latency to the counter at that cycle, and assert pass and latency_valid in the same cycle as the final match_valid.
REQ-016 SHALL go to FAIL and assert fail when the counter reaches TIMEOUT-1 with no final match.
REQ-017 SHALL let the final match take priority over timeout when both occur in the same cycle.
REQ-018 SHALL return to IDLE from any state on abort without asserting pass or fail; abort SHALL take priority over start and over matching.
REQ-019 SHALL hold pass, fail and latency sticky until the next accepted start or abort.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL assert busy exactly when the state is RUN.

Reset
REQ-022 SHALL, on axis_rst_n low at a clock edge, set the state to IDLE.
REQ-023 SHALL reset all outputs to 0: busy, pass, fail, match_valid, match_idx, match_cycle, latency, latency_valid.
REQ-024 SHALL NOT reset sequence storage contents; entries are undefined until written.
REQ-025 SHALL, on reset during RUN, abandon the run with no pass or fail.

Structure
REQ-026 SHALL place the state enum and default parameter constants in package checkbits_mon_pkg.
REQ-027 SHALL implement sequence storage as sub-module checkbits_seq_mem: DEPTH x 2*WIDTH register file, one write port, one combinational read port.
REQ-028 SHALL use no clock other than axis_clk and no asynchronous logic.

Verification
REQ-029 SHALL cover a masked two-entry run: entries {0x00A5, mask 0x00FF}, {0xFF5A, mask 0xFFFF}, length 2; drive 0x12A5 at cycle 3 and 0xFF5A at cycle 10 -> match pulses with idx 0 / cycle 3 and idx 1 / cycle 10, pass=1, latency=10.
REQ-030 SHALL cover an ordered five-entry run: 40, 893, 2541, 2669, 0xAB71 with full mask, with junk values between and 893 driven before 40 -> 893 ignored until 40 has matched, pass after 0xAB71.
REQ-031 SHALL cover a same-cycle double match: entries 0x0001, 0x0001; hold 0x0001 for 1 cycle -> only idx 0 matches; held 2 cycles -> pass.
REQ-032 SHALL cover timeout: TIMEOUT=100, expected value never driven -> fail=1 at counter 99; final match exactly at cycle 99 -> pass, not fail.
REQ-033 SHALL cover abort and reset mid-run: abort at cycle 5 -> IDLE, pass=0, fail=0; axis_rst_n low mid-run -> all outputs 0; cfg_we during RUN leaves the entry unchanged.
REQ-034 SHALL cover restart: start from PASS with cfg_len=0 -> ignored and outputs held; start with cfg_len=3 -> pass and latency_valid cleared, new run begins.
